// File: rtl/gcd_stein_param.sv
// Binary (Stein) GCD core: strips common factors of two in q_Sub, restores them in q_Mult.
// Start/Ack handshake, CEN single-step gating, one-hot state outputs, saturating cycle counter.
module gcd_stein_param #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1,
    parameter int CYC_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             CEN,
    input  logic             Start,
    input  logic             Ack,
    input  logic [WIDTH-1:0] Ain,
    input  logic [WIDTH-1:0] Bin,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] AB_GCD,
    output logic [CNT_W-1:0] i_count,
    output logic [CYC_W-1:0] Cycles,
    output logic             q_I,
    output logic             q_Sub,
    output logic             q_Mult,
    output logic             q_Done
);

    typedef enum logic [1:0] {S_I, S_SUB, S_MULT, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, gcd_q, gcd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d, cyc_inc;

    assign cyc_inc = (&cyc_q) ? cyc_q : cyc_q + 1'b1;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        gcd_d   = gcd_q;
        cnt_d   = cnt_q;
        cyc_d   = cyc_q;
        case (state_q)
            S_I: begin
                if (Start) begin
                    a_d     = Ain;
                    b_d     = Bin;
                    gcd_d   = '0;
                    cnt_d   = '0;
                    cyc_d   = '0;
                    state_d = S_SUB;
                end
            end
            S_SUB: begin
                cyc_d = cyc_inc;
                // Rule order matters: zero checks first, and A>B guards the subtraction.
                if (a_q == '0) begin
                    gcd_d   = b_q;
                    state_d = S_DONE;
                end else if (b_q == '0) begin
                    gcd_d   = a_q;
                    state_d = S_DONE;
                end else if (a_q == b_q) begin
                    gcd_d   = a_q;
                    state_d = (cnt_q == '0) ? S_DONE : S_MULT;
                end else if (!a_q[0] && !b_q[0]) begin
                    a_d   = a_q >> 1;
                    b_d   = b_q >> 1;
                    cnt_d = cnt_q + 1'b1;
                end else if (!a_q[0]) begin
                    a_d = a_q >> 1;
                end else if (!b_q[0]) begin
                    b_d = b_q >> 1;
                end else if (a_q > b_q) begin
                    a_d = a_q - b_q;
                end else begin
                    b_d = b_q - a_q;
                end
            end
            S_MULT: begin
                gcd_d = gcd_q << 1;
                cnt_d = cnt_q - 1'b1;
                cyc_d = cyc_inc;
                if (cnt_q == CNT_W'(1)) state_d = S_DONE;
            end
            S_DONE: begin
                if (Ack) state_d = S_I;
            end
            default: state_d = S_I;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_I;
            a_q     <= '0;
            b_q     <= '0;
            gcd_q   <= '0;
            cnt_q   <= '0;
            cyc_q   <= '0;
        end else if (CEN) begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            gcd_q   <= gcd_d;
            cnt_q   <= cnt_d;
            cyc_q   <= cyc_d;
        end
    end

    assign A       = a_q;
    assign B       = b_q;
    assign AB_GCD  = gcd_q;
    assign i_count = cnt_q;
    assign Cycles  = cyc_q;
    assign q_I     = (state_q == S_I);
    assign q_Sub   = (state_q == S_SUB);
    assign q_Mult  = (state_q == S_MULT);
    assign q_Done  = (state_q == S_DONE);

endmodule

// File: tb/tb_gcd_stein_param.sv
// Scoreboard bench for gcd_stein_param: 8-bit instance for most scenarios, 16-bit instance for the wide case.
module tb_gcd_stein_param;

    logic        Clk, Reset, CEN, Start, Ack;
    logic [7:0]  Ain, Bin, A, B, AB_GCD;
    logic [3:0]  i_count;
    logic [15:0] Cycles;
    logic        q_I, q_Sub, q_Mult, q_Done;

    logic        Start16, Ack16;
    logic [15:0] Ain16, Bin16, A16, B16, G16, cy16;
    logic [4:0]  ic16;
    logic        qI16, qSub16, qMult16, qDone16;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  exp_gcd_q[$];
    int          exp_cyc_q[$];
    logic [15:0] exp16_q[$];

    gcd_stein_param #(.WIDTH(8)) dut (
        .Clk(Clk), .Reset(Reset), .CEN(CEN), .Start(Start), .Ack(Ack),
        .Ain(Ain), .Bin(Bin), .A(A), .B(B), .AB_GCD(AB_GCD),
        .i_count(i_count), .Cycles(Cycles),
        .q_I(q_I), .q_Sub(q_Sub), .q_Mult(q_Mult), .q_Done(q_Done)
    );

    gcd_stein_param #(.WIDTH(16)) dut16 (
        .Clk(Clk), .Reset(Reset), .CEN(CEN), .Start(Start16), .Ack(Ack16),
        .Ain(Ain16), .Bin(Bin16), .A(A16), .B(B16), .AB_GCD(G16),
        .i_count(ic16), .Cycles(cy16),
        .q_I(qI16), .q_Sub(qSub16), .q_Mult(qMult16), .q_Done(qDone16)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Euclid reference, deliberately a different algorithm from the design.
    function automatic logic [15:0] ref_gcd(input logic [15:0] x_in, input logic [15:0] y_in);
        logic [15:0] x, y, t;
        x = x_in;
        y = y_in;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic test_reset();
        Reset = 1'b1; CEN = 1'b0; Start = 1'b0; Ack = 1'b0; Ain = 8'd0; Bin = 8'd0;
        Start16 = 1'b0; Ack16 = 1'b0; Ain16 = 16'd0; Bin16 = 16'd0;
        repeat (2) @(negedge Clk);
        n_checks++;
        if ({q_I, q_Sub, q_Mult, q_Done} !== 4'b1000 || A !== 8'd0 || B !== 8'd0 ||
            AB_GCD !== 8'd0 || i_count !== 4'd0 || Cycles !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_state: state=%b A=%0d B=%0d G=%0d i=%0d cyc=%0d, want 1000 and zeros",
                     {q_I, q_Sub, q_Mult, q_Done}, A, B, AB_GCD, i_count, Cycles);
        end
        Reset = 1'b0; CEN = 1'b1;
    endtask

    task automatic run_gcd(input logic [7:0] a, input logic [7:0] b, input int exp_cyc,
                           input bit tog, input bit noise);
        int          n_en, n_all, ec;
        logic [7:0]  eg;
        logic [47:0] snap;
        logic        cen_now;
        @(negedge Clk);
        if (noise) begin
            Ack = 1'b1;
            @(negedge Clk);
            Ack = 1'b0;
            n_checks++;
            if (q_I !== 1'b1) begin
                n_fail++;
                $display("FAIL ack_in_idle: q_I=%b, want 1", q_I);
            end
        end
        Ain = a; Bin = b; Start = 1'b1; CEN = 1'b1;
        exp_gcd_q.push_back(ref_gcd({8'd0, a}, {8'd0, b})[7:0]);
        exp_cyc_q.push_back(exp_cyc);
        @(negedge Clk);
        Start = 1'b0; Ain = ~a; Bin = a ^ b ^ 8'h5a;
        n_checks++;
        if (q_Sub !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_%0d_%0d: q_Sub=%b, want 1", a, b, q_Sub);
        end
        n_en = 1; n_all = 1;
        while (!q_Done && n_all < 2000) begin
            if (tog) CEN = ~CEN;
            Start = noise && n_all < 4;
            Ack   = noise && n_all == 1;
            snap = {A, B, AB_GCD, i_count, Cycles, q_I, q_Sub, q_Mult, q_Done};
            cen_now = CEN;
            @(negedge Clk);
            n_all++;
            if (cen_now) n_en++;
            else begin
                n_checks++;
                if ({A, B, AB_GCD, i_count, Cycles, q_I, q_Sub, q_Mult, q_Done} !== snap) begin
                    n_fail++;
                    $display("FAIL freeze_cen0: regs=%h, want %h",
                             {A, B, AB_GCD, i_count, Cycles, q_I, q_Sub, q_Mult, q_Done}, snap);
                end
            end
            n_checks++;
            if (!$onehot({q_I, q_Sub, q_Mult, q_Done})) begin
                n_fail++;
                $display("FAIL onehot: state=%b, want one hot", {q_I, q_Sub, q_Mult, q_Done});
            end
        end
        Start = 1'b0; Ack = 1'b0; CEN = 1'b1;
        eg = exp_gcd_q.pop_front();
        ec = exp_cyc_q.pop_front();
        n_checks++;
        if (!q_Done) begin
            n_fail++;
            $display("FAIL done_timeout_%0d_%0d: no q_Done after %0d cycles", a, b, n_all);
        end
        n_checks++;
        if (AB_GCD !== eg || i_count !== 4'd0) begin
            n_fail++;
            $display("FAIL result_%0d_%0d: G=%0d i=%0d, want G=%0d i=0", a, b, AB_GCD, i_count, eg);
        end
        if (ec >= 0) begin
            n_checks++;
            if (Cycles !== 16'(ec) || n_en !== ec + 1) begin
                n_fail++;
                $display("FAIL cycles_%0d_%0d: Cycles=%0d latency=%0d, want %0d and %0d",
                         a, b, Cycles, n_en, ec, ec + 1);
            end
            if (tog) begin
                n_checks++;
                if (n_all !== 2 * ec + 1) begin
                    n_fail++;
                    $display("FAIL stretched_latency: %0d edges, want %0d", n_all, 2 * ec + 1);
                end
            end
        end
        Start = noise;
        repeat (2) @(negedge Clk);
        Start = 1'b0;
        n_checks++;
        if (q_Done !== 1'b1 || AB_GCD !== eg) begin
            n_fail++;
            $display("FAIL done_hold: q_Done=%b G=%0d, want 1 and %0d", q_Done, AB_GCD, eg);
        end
        Ack = 1'b1;
        @(negedge Clk);
        Ack = 1'b0;
        n_checks++;
        if (q_I !== 1'b1 || AB_GCD !== eg) begin
            n_fail++;
            $display("FAIL ack_return: q_I=%b G=%0d, want 1 and %0d", q_I, AB_GCD, eg);
        end
    endtask

    task automatic test_basic();
        run_gcd(8'd36, 8'd24, 8, 1'b0, 1'b0);
        run_gcd(8'd5,  8'd15, 3, 1'b0, 1'b0);
        run_gcd(8'd0,  8'd20, 1, 1'b0, 1'b0);
        run_gcd(8'd0,  8'd0,  1, 1'b0, 1'b0);
        run_gcd(8'd20, 8'd0,  1, 1'b0, 1'b0);
    endtask

    task automatic test_cen_toggle();
        run_gcd(8'd36, 8'd24, 8, 1'b1, 1'b0);
    endtask

    task automatic test_ignored_handshake();
        run_gcd(8'd36, 8'd24, 8, 1'b0, 1'b1);
    endtask

    task automatic test_wide();
        int          n;
        logic [4:0]  peak;
        logic [15:0] eg;
        @(negedge Clk);
        Ain16 = 16'd61440; Bin16 = 16'd4096; Start16 = 1'b1;
        exp16_q.push_back(ref_gcd(16'd61440, 16'd4096));
        @(negedge Clk);
        Start16 = 1'b0;
        n = 0; peak = 5'd0;
        while (!qDone16 && n < 500) begin
            if (ic16 > peak) peak = ic16;
            @(negedge Clk);
            n++;
        end
        eg = exp16_q.pop_front();
        n_checks++;
        if (G16 !== eg || peak !== 5'd12 || cy16 !== 16'd31 || qDone16 !== 1'b1) begin
            n_fail++;
            $display("FAIL wide_61440_4096: G=%0d peak_i=%0d cyc=%0d done=%b, want %0d 12 31 1",
                     G16, peak, cy16, qDone16, eg);
        end
        Ack16 = 1'b1;
        @(negedge Clk);
        Ack16 = 1'b0;
        n_checks++;
        if (qI16 !== 1'b1) begin
            n_fail++;
            $display("FAIL wide_ack: q_I=%b, want 1", qI16);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        @(negedge Clk);
        Ain = 8'd36; Bin = 8'd24; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        n = 0;
        while (!q_Mult && n < 50) begin
            @(negedge Clk);
            n++;
        end
        n_checks++;
        if (q_Mult !== 1'b1) begin
            n_fail++;
            $display("FAIL reach_mult: q_Mult=%b after %0d cycles, want 1", q_Mult, n);
        end
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        n_checks++;
        if ({q_I, q_Sub, q_Mult, q_Done} !== 4'b1000 || A !== 8'd0 || B !== 8'd0 ||
            AB_GCD !== 8'd0 || i_count !== 4'd0 || Cycles !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_mid: state=%b A=%0d B=%0d G=%0d i=%0d cyc=%0d, want 1000 and zeros",
                     {q_I, q_Sub, q_Mult, q_Done}, A, B, AB_GCD, i_count, Cycles);
        end
        run_gcd(8'd36, 8'd24, 8, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++)
            run_gcd(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), -1, i[0], 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_cen_toggle();
        test_ignored_handshake();
        test_wide();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
